// File: rtl/fsm_updown_pkg.sv
// rtl/fsm_updown_pkg.sv - shared state and delta-class definitions for the up/down decoder
// Contents:
//   state_t : decoder FSM states (IDLE, LOCKED, FAULT)
//   delta_t : class of (q_in - prev) mod 4 (HOLD, UP, ILLEGAL, DOWN)
package fsm_updown_pkg;

   localparam int POS_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   // Encoded so that the class value equals the modulo-4 difference itself.
   typedef enum logic [1:0] {
      DELTA_HOLD    = 2'd0,
      DELTA_UP      = 2'd1,
      DELTA_ILLEGAL = 2'd2,
      DELTA_DOWN    = 2'd3
   } delta_t;

endpackage

// File: rtl/updown_delta_classify.sv
// rtl/updown_delta_classify.sv - combinational classifier of a 2-bit counter step
// Ports:
//   q_in  : in  [1:0] current counter code
//   prev  : in  [1:0] last accepted counter code
//   delta : out delta_t class of (q_in - prev) mod 4
module updown_delta_classify
   import fsm_updown_pkg::*;
(
   input  logic [1:0] q_in,
   input  logic [1:0] prev,
   output delta_t     delta
);

   logic [1:0] diff;

   // Two-bit subtraction wraps naturally, giving the modulo-4 difference.
   always_comb begin
      diff  = q_in - prev;
      delta = delta_t'(diff);
   end

endmodule

// File: rtl/fsm_updown_decoder_2bit.sv
// rtl/fsm_updown_decoder_2bit.sv - decodes a sampled 2-bit up/down counter into position and direction
// Ports:
//   clk    : in  rising-edge clock
//   rst    : in  synchronous active-high reset
//   q_in   : in  [1:0] sampled counter code
//   valid  : in  q_in qualifier
//   dir    : out last decoded direction (1 = up, 0 = down)
//   step   : out one-cycle pulse per legal count change
//   err    : out one-cycle pulse on an illegal jump
//   locked : out high while in LOCKED
//   pos    : out [POS_W-1:0] decoded position, modulo 2**POS_W
module fsm_updown_decoder_2bit
   import fsm_updown_pkg::*;
#(
   parameter int POS_W = POS_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       q_in,
   input  logic             valid,
   output logic             dir,
   output logic             step,
   output logic             err,
   output logic             locked,
   output logic [POS_W-1:0] pos
);

   state_t           state, state_d;
   logic [1:0]       prev, prev_d;
   logic [POS_W-1:0] pos_d;
   logic             dir_d, step_d, err_d;
   delta_t           delta;

   updown_delta_classify u_classify (
      .q_in  (q_in),
      .prev  (prev),
      .delta (delta)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         prev  <= 2'b00;
         pos   <= '0;
         dir   <= 1'b0;
         step  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_d;
         prev  <= prev_d;
         pos   <= pos_d;
         dir   <= dir_d;
         step  <= step_d;
         err   <= err_d;
      end
   end

   // Derived from the state register, so it is registered like the other outputs.
   assign locked = (state == ST_LOCKED);

   always_comb begin
      state_d = state;
      prev_d  = prev;
      pos_d   = pos;
      dir_d   = dir;
      step_d  = 1'b0;
      err_d   = 1'b0;

      if (valid) begin
         // Every accepted sample becomes the new reference, including illegal ones.
         prev_d = q_in;
         case (state)
            ST_IDLE: begin
               state_d = ST_LOCKED;
            end
            ST_LOCKED, ST_FAULT: begin
               case (delta)
                  DELTA_UP: begin
                     step_d  = 1'b1;
                     dir_d   = 1'b1;
                     pos_d   = pos + POS_W'(1);
                     state_d = ST_LOCKED;
                  end
                  DELTA_DOWN: begin
                     step_d  = 1'b1;
                     dir_d   = 1'b0;
                     pos_d   = pos - POS_W'(1);
                     state_d = ST_LOCKED;
                  end
                  DELTA_ILLEGAL: begin
                     err_d   = 1'b1;
                     state_d = ST_FAULT;
                  end
                  default: begin
                     state_d = state;
                  end
               endcase
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_updown_decoder_2bit.sv
// tb/tb_fsm_updown_decoder_2bit.sv - self-checking bench for fsm_updown_decoder_2bit
module tb_fsm_updown_decoder_2bit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] q_in = 2'b00;
   logic       valid = 1'b0;
   logic       dir, step, err, locked;
   logic [7:0] pos;

   int checks = 0;
   int errors = 0;

   fsm_updown_decoder_2bit #(.POS_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .q_in   (q_in),
      .valid  (valid),
      .dir    (dir),
      .step   (step),
      .err    (err),
      .locked (locked),
      .pos    (pos)
   );

   always #5 clk = ~clk;

   // Behavioural reference: mode 0 = idle, 1 = locked, 2 = fault.
   int m_mode = 0;
   int m_prev = 0;
   int m_pos  = 0;
   int m_dir  = 0;
   int m_step = 0;
   int m_err  = 0;
   bit started = 0;

   function automatic int delta_of(input int q, input int p);
      return (q + 4 - p) % 4;
   endfunction

   always @(posedge clk) begin
      started <= 1'b1;
      m_step  <= 0;
      m_err   <= 0;
      if (rst) begin
         m_mode <= 0;
         m_prev <= 0;
         m_pos  <= 0;
         m_dir  <= 0;
      end else if (valid) begin
         m_prev <= int'(q_in);
         if (m_mode == 0) begin
            m_mode <= 1;
         end else if (delta_of(int'(q_in), m_prev) == 1) begin
            m_step <= 1; m_dir <= 1; m_pos <= (m_pos + 1) % 256; m_mode <= 1;
         end else if (delta_of(int'(q_in), m_prev) == 3) begin
            m_step <= 1; m_dir <= 0; m_pos <= (m_pos + 255) % 256; m_mode <= 1;
         end else if (delta_of(int'(q_in), m_prev) == 2) begin
            m_err <= 1; m_mode <= 2;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("model_pos",    int'(pos),    m_pos);
         chk("model_dir",    int'(dir),    m_dir);
         chk("model_step",   int'(step),   m_step);
         chk("model_err",    int'(err),    m_err);
         chk("model_locked", int'(locked), (m_mode == 1) ? 1 : 0);
         chk("step_err_excl", int'(step & err), 0);
      end
   end

   // Applies inputs for one rising edge and returns at the following falling edge.
   task automatic cyc(input logic r, input logic v, input logic [1:0] q);
      rst = r; valid = v; q_in = q;
      @(negedge clk);
   endtask

   int nsteps;

   initial begin
      @(negedge clk);
      cyc(1'b1, 1'b0, 2'd0);
      chk("rst_pos", int'(pos), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_dir", int'(dir), 0);
      chk("rst_pulses", int'(step) + int'(err), 0);

      // Up sequence from reset.
      cyc(1'b0, 1'b1, 2'd0);
      chk("first_locked", int'(locked), 1);
      chk("first_step", int'(step), 0);
      chk("first_pos", int'(pos), 0);
      nsteps = 0;
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 1'b1, 2'(i % 4));
         nsteps += int'(step);
      end
      chk("up_steps", nsteps, 4);
      chk("up_dir", int'(dir), 1);
      chk("up_pos", int'(pos), 4);

      // Down from pos=4, prev=00.
      nsteps = 0;
      cyc(1'b0, 1'b1, 2'd3); nsteps += int'(step);
      cyc(1'b0, 1'b1, 2'd2); nsteps += int'(step);
      chk("down_steps", nsteps, 2);
      chk("down_dir", int'(dir), 0);
      chk("down_pos", int'(pos), 2);

      // Wrap down then up.
      cyc(1'b1, 1'b0, 2'd0);
      cyc(1'b0, 1'b1, 2'd0);
      cyc(1'b0, 1'b1, 2'd3);
      chk("wrapdn_pos", int'(pos), 255);
      chk("wrapdn_dir", int'(dir), 0);
      cyc(1'b0, 1'b1, 2'd0);
      chk("wrapup_pos", int'(pos), 0);
      chk("wrapup_dir", int'(dir), 1);

      // Illegal jump, fault hold, recovery.
      cyc(1'b0, 1'b1, 2'd1);
      chk("pre_fault_pos", int'(pos), 1);
      cyc(1'b0, 1'b1, 2'd3);
      chk("fault_err", int'(err), 1);
      chk("fault_locked", int'(locked), 0);
      chk("fault_pos", int'(pos), 1);
      cyc(1'b0, 1'b1, 2'd3);
      chk("fault_hold_pulses", int'(step) + int'(err), 0);
      chk("fault_hold_locked", int'(locked), 0);
      cyc(1'b0, 1'b1, 2'd0);
      chk("recover_step", int'(step), 1);
      chk("recover_pos", int'(pos), 2);
      chk("recover_locked", int'(locked), 1);

      // valid toggling during an up sequence (prev=00, pos=2).
      cyc(1'b0, 1'b1, 2'd1);
      chk("tog_pos_a", int'(pos), 3);
      cyc(1'b0, 1'b0, 2'd2);
      chk("tog_hold_pos", int'(pos), 3);
      chk("tog_hold_step", int'(step), 0);
      cyc(1'b0, 1'b1, 2'd2);
      chk("tog_pos_b", int'(pos), 4);
      cyc(1'b0, 1'b0, 2'd0);
      chk("tog_noerr", int'(err), 0);
      chk("tog_hold_pos2", int'(pos), 4);

      // Fault twice, then reset with a valid sample in FAULT.
      cyc(1'b0, 1'b1, 2'd0);
      chk("fault2_err_a", int'(err), 1);
      cyc(1'b0, 1'b1, 2'd2);
      chk("fault2_err_b", int'(err), 1);
      chk("fault2_locked", int'(locked), 0);
      cyc(1'b1, 1'b1, 2'd1);
      chk("rstfault_pos", int'(pos), 0);
      chk("rstfault_locked", int'(locked), 0);
      chk("rstfault_pulses", int'(step) + int'(err), 0);
      cyc(1'b0, 1'b1, 2'd2);
      chk("reacq_step", int'(step), 0);
      chk("reacq_err", int'(err), 0);
      chk("reacq_pos", int'(pos), 0);
      chk("reacq_locked", int'(locked), 1);

      // Randomized run, checked every cycle by the compare process.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
             2'($urandom_range(0, 3)));
      end
      cyc(1'b0, 1'b0, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
